quad_debounce_counter: RTL
==========================

Name: quad_debounce_counter

Overview:
- Per-encoder front end that sits between the RS422 differential receivers and the Avalon quadrature register block.
- Takes single-ended A/B (and optionally index) levels from a possibly asynchronous, bouncy source, then synchronizes, debounces and 4x-decodes them.
- Maintains a signed position count, a periodic velocity sample and an illegal-transition counter.
- The register block instantiates one per encoder and reads `count` directly.

Parameters:
- DEBOUNCE_TICKS, 5: consecutive cycles a new synchronized level must persist before acceptance; legal range 1..255.
- CLOCK_FREQ_HZ, 50_000_000: clock frequency; informational, used only to derive the VEL_PERIOD_CYCLES default.
- VEL_PERIOD_CYCLES, CLOCK_FREQ_HZ/1000: velocity sample period in cycles (1 ms); legal range ≥2.
- COUNT_WIDTH, 32: width of `count`, `velocity` and `index_pos`.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset; 0 = reset asserted
- `quadA`  in  1  encoder channel A, asynchronous to `clk`
- `quadB`  in  1  encoder channel B, asynchronous to `clk`
- `clear`  in  1  synchronous one-cycle request to zero the position
- `count`  out  COUNT_WIDTH  signed position, two's complement
- `velocity`  out  COUNT_WIDTH  signed counts per sample period
- `vel_valid`  out  1  one-cycle pulse when `velocity` updates
- `err_count`  out  16  saturating count of illegal transitions
- `dir`  out  1  direction of the last legal step: 1 = up, 0 = down

Behaviour:
- Reset (`reset`=0, asynchronous):
  - `count`, `velocity`, `err_count`, velocity timer and sample reference = 0.
  - `vel_valid` = 0, `dir` = 0.
  - Sync flops, debounced A/B and previous-state register = 0.
  - Debounce counters = 0.
  - Release is synchronous to `clk`; no step is counted from the post-reset state.
- Synchronizer: two flops per channel.
- Debounce, per channel:
  - If sync == debounced, counter <= 0.
  - Otherwise counter increments; when it reaches DEBOUNCE_TICKS-1 while still differing, debounced <= sync and counter <= 0.
  - A glitch shorter than DEBOUNCE_TICKS cycles never reaches the decoder.
- Latency: `count` updates exactly DEBOUNCE_TICKS+3 rising edges after a clean raw transition (2 sync + DEBOUNCE_TICKS + 1 decode).
- Decode, comparing previous {A,B} with debounced {A,B} each cycle:
  - Sequence 00→10→11→01→00: +1, `dir` <= 1.
  - Reverse order: -1, `dir` <= 0.
  - No change: hold.
  - Both bits change in the same cycle: illegal. `count` holds, `err_count` += 1 saturating at 0xFFFF, previous state still updates.
- Arithmetic: `count` wraps modulo 2^COUNT_WIDTH; max positive +1 → min negative.
- `clear`:
  - Sets `count` <= 0 and the velocity sample reference <= 0.
  - `clear` wins over a simultaneous step; that step is lost.
  - `err_count` is not cleared.
- Velocity:
  - A free-running timer counts 0..VEL_PERIOD_CYCLES-1.
  - On terminal count: `velocity` <= `count` - reference (modulo 2^COUNT_WIDTH, so wrap-correct), reference <= `count`, `vel_valid` = 1 for that single cycle.
  - A step landing in the terminal cycle is counted in the next period.
- All outputs are registered.

Optional Feature:
- Macro: QUAD_INDEX_EN.
- Defined:
  - Adds ports `quadI` in 1, `index_pos` out COUNT_WIDTH, `index_seen` out 1.
  - `quadI` uses the same sync + debounce path.
  - On the debounced rising edge of the index: `index_pos` <= `count` value after that cycle's step; `index_seen` pulses 1 cycle.
  - Reset values: `index_pos` = 0, `index_seen` = 0.
  - `clear` does not affect `index_pos`.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan (DEBOUNCE_TICKS=5, VEL_PERIOD_CYCLES=100):
- Reset, then 8 clean forward steps 00→10→11→01→00→… with each level held 20 cycles → `count`=8, `dir`=1, `err_count`=0; first increment exactly 8 edges after the first A rise.
- Forward 8 steps, reverse 3 → `count`=5, `dir`=0; 3-cycle glitch on A → `count` unchanged.
- Force AB 00→11 in one cycle → `err_count`=1, `count` unchanged; following 11→01 counts +1.
- Preload `count` to 0x7FFFFFFF via steps/force, one forward step → 0x80000000; next velocity window reports +1, not a huge negative value.
- 10 forward steps within one window → `vel_valid` pulse, `velocity`=10; `clear` asserted in the same cycle as a step → `count`=0, next `velocity`=steps since clear.
- Assert `reset`=0 mid-motion, asynchronously between edges → all outputs 0 immediately; after release, the first legal step gives `count`=±1. With QUAD_INDEX_EN: index pulse at `count`=42 → `index_pos`=42, `index_seen` 1 cycle.

Source files
------------

// File: rtl/quad_debounce_counter.sv
// Quadrature encoder front end: 2-flop sync, per-channel debounce, 4x decode,
// position/velocity/error counters. Define QUAD_INDEX_EN to add index capture.
module quad_debounce_counter #(
  parameter int DEBOUNCE_TICKS    = 5,
  parameter int CLOCK_FREQ_HZ     = 50_000_000,
  parameter int VEL_PERIOD_CYCLES = CLOCK_FREQ_HZ / 1000,
  parameter int COUNT_WIDTH       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   quadA,
  input  logic                   quadB,
`ifdef QUAD_INDEX_EN
  input  logic                   quadI,
  output logic [COUNT_WIDTH-1:0] index_pos,
  output logic                   index_seen,
`endif
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [COUNT_WIDTH-1:0] velocity,
  output logic                   vel_valid,
  output logic [15:0]            err_count,
  output logic                   dir
);

`ifdef QUAD_INDEX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif
  localparam int TW = (VEL_PERIOD_CYCLES > 1) ? $clog2(VEL_PERIOD_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(VEL_PERIOD_CYCLES - 1);
  localparam logic [7:0]    DB_LAST = 8'(DEBOUNCE_TICKS - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1, sync2, db;
  logic [7:0]     db_cnt [NCH];

  // Channel order in every vector: bit0 = A, bit1 = B, bit2 = index.
`ifdef QUAD_INDEX_EN
  assign raw = {quadI, quadB, quadA};
`else
  assign raw = {quadB, quadA};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  logic [1:0]             prev_ab, cur_ab;
  logic [1:0]             prev_idx, cur_idx;
  logic                   step_up, step_dn, illegal;
  logic [COUNT_WIDTH-1:0] count_next;

  // Phase index along 00->10->11->01 is {B, A^B}, so a forward step is +1 mod 4.
  always_comb begin
    cur_ab     = {db[0], db[1]};
    prev_idx   = {prev_ab[0], prev_ab[1] ^ prev_ab[0]};
    cur_idx    = {cur_ab[0], cur_ab[1] ^ cur_ab[0]};
    step_up    = (cur_idx == prev_idx + 2'd1);
    step_dn    = (cur_idx == prev_idx - 2'd1);
    illegal    = ((prev_ab ^ cur_ab) == 2'b11);
    count_next = count;
    if (clear)        count_next = '0;
    else if (step_up) count_next = count + 1'b1;
    else if (step_dn) count_next = count - 1'b1;
  end

  logic [TW-1:0]          vel_timer;
  logic [COUNT_WIDTH-1:0] vel_ref;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_ab   <= '0;
      count     <= '0;
      dir       <= 1'b0;
      err_count <= '0;
      vel_timer <= '0;
      vel_ref   <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      count   <= count_next;
      if (step_up)      dir <= 1'b1;
      else if (step_dn) dir <= 1'b0;
      if (illegal && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      // Sample uses the registered count, so a step in the terminal cycle lands in the next period.
      if (vel_timer == T_LAST) begin
        vel_timer <= '0;
        velocity  <= count - vel_ref;
        vel_ref   <= count;
        vel_valid <= 1'b1;
      end else begin
        vel_timer <= vel_timer + TW'(1);
        vel_valid <= 1'b0;
      end
      if (clear) vel_ref <= '0;
    end
  end

`ifdef QUAD_INDEX_EN
  logic idx_prev;
  logic idx_rise;

  assign idx_rise = db[2] & ~idx_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_prev   <= 1'b0;
      index_seen <= 1'b0;
      index_pos  <= '0;
    end else begin
      idx_prev   <= db[2];
      index_seen <= idx_rise;
      if (idx_rise) index_pos <= count_next;
    end
  end
`endif

endmodule
